// File: rtl/accum_result_packer_if.sv
// Packed-word stream from the result packer toward the NoC injection port.
interface accum_result_packer_if #(
  parameter int DATAW = 32,
  parameter int LANES = 4,
  parameter int CNTW  = $clog2(LANES+1)
);
  logic                   o_valid;
  logic                   o_ready;
  logic [LANES*DATAW-1:0] o_data;
  logic [CNTW-1:0]        o_count;
  logic                   o_last;

  modport master (output o_valid, o_data, o_count, o_last, input o_ready);
  modport slave  (input o_valid, o_data, o_count, o_last, output o_ready);
endinterface

// File: rtl/accum_result_packer.sv
// Shift/ReLU each accumulator result, pack LANES of them per word, and buffer
// the words in a first-word-fall-through FIFO drained over valid/ready.
module accum_result_packer #(
  parameter int DATAW = 32,
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int CNTW  = $clog2(LANES+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATAW-1:0]      i_result,
  input  logic                  i_last,
  input  logic [4:0]            cfg_shift,
  input  logic                  cfg_relu,
  accum_result_packer_if.master out,
  output logic                  o_almost_full,
  output logic                  o_overflow
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [LANES-1:0][DATAW-1:0] data;
    logic [CNTW-1:0]             cnt;
    logic                        last;
  } word_t;

  // Stage 1: per-element shift and ReLU
  logic                    r_s1_vld, r_s1_last;
  logic signed [DATAW-1:0] r_s1_y;
  logic signed [DATAW-1:0] w_shift, w_y;

  assign w_shift = $signed(i_result) >>> cfg_shift;
  assign w_y     = (cfg_relu && w_shift[DATAW-1]) ? '0 : w_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_y    <= '0;
      r_s1_last <= 1'b0;
    end else begin
      r_s1_vld <= i_valid;
      if (i_valid) begin
        r_s1_y    <= w_y;
        r_s1_last <= i_last;
      end
    end
  end

  // Stage 2: lane packing; pack register is cleared on completion so
  // lanes beyond the count of a short word are already zero.
  logic [LW-1:0]               r_lane;
  logic [LANES-1:0][DATAW-1:0] r_pack, w_pack;
  logic                        w_done;
  logic                        r_push;
  word_t                       r_pw;

  always_comb begin
    w_pack         = r_pack;
    w_pack[r_lane] = r_s1_y;
  end

  assign w_done = (r_lane == LW'(LANES-1)) || r_s1_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_pack <= '0;
      r_push <= 1'b0;
      r_pw   <= '0;
    end else begin
      r_push <= r_s1_vld && w_done;
      if (r_s1_vld) begin
        if (w_done) begin
          r_pw   <= '{data: w_pack, cnt: CNTW'(r_lane) + CNTW'(1), last: r_s1_last};
          r_lane <= '0;
          r_pack <= '0;
        end else begin
          r_pack <= w_pack;
          r_lane <= r_lane + 1'b1;
        end
      end
    end
  end

  // Stage 3: FIFO; a push into a full FIFO survives only if the head pops.
  word_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [OW-1:0]  r_occ, w_occ_nxt;
  logic           w_pop, w_full, w_wr;
  word_t          w_head;

  assign w_pop  = out.o_valid && out.o_ready;
  assign w_full = (r_occ == OW'(DEPTH));
  assign w_wr   = r_push && (!w_full || w_pop);

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_wr, w_pop})
      2'b10:   w_occ_nxt = r_occ + 1'b1;
      2'b01:   w_occ_nxt = r_occ - 1'b1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_pw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_occ         <= '0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_occ         <= w_occ_nxt;
      o_almost_full <= (w_occ_nxt >= OW'(DEPTH-2));
      if (r_push && !w_wr) o_overflow <= 1'b1;
    end
  end

  // Head fields are gated so an empty FIFO presents all-zero outputs.
  assign w_head      = r_mem[r_rptr];
  assign out.o_valid = (r_occ != '0);
  assign out.o_data  = out.o_valid ? w_head.data : '0;
  assign out.o_count = out.o_valid ? w_head.cnt  : '0;
  assign out.o_last  = out.o_valid ? w_head.last : 1'b0;
endmodule

// File: tb/tb_accum_result_packer.sv
// Directed bench for accum_result_packer: queue-level reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_accum_result_packer;
  localparam int DATAW = 32;
  localparam int LANES = 4;
  localparam int DEPTH = 16;
  localparam int W     = LANES*DATAW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_result = '0;
  logic        i_last = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_relu = 1'b0;
  logic        o_almost_full, o_overflow;

  accum_result_packer_if #(.DATAW(DATAW), .LANES(LANES)) ifc();

  accum_result_packer #(.DATAW(DATAW), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_result(i_result), .i_last(i_last),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .out(ifc),
    .o_almost_full(o_almost_full), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
    bit           last;
  } wd_t;

  wd_t         mq[$];
  logic [31:0] part[$];
  wd_t         d1, d2;
  bit          d1v = 0, d2v = 0, m_af = 0, m_ov = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Floor division by 2^s, then optional clamp of negatives.
  function automatic logic [31:0] proc(input logic [31:0] x, input int s, input bit relu);
    longint v, p, y;
    v = longint'($signed(x));
    p = longint'(1) << s;
    y = v / p;
    if (v < 0 && (v % p) != 0) y = y - 1;
    if (relu && y < 0) y = 0;
    return 32'(y);
  endfunction

  task automatic model_clear();
    mq.delete(); part.delete();
    d1v = 0; d2v = 0; m_af = 0; m_ov = 0;
  endtask

  // One clock edge of the reference: words enter the FIFO two edges after
  // the completing element is sampled.
  task automatic model_edge(input bit v, input logic [31:0] x, input bit l, input bit rdy);
    if (rst) begin
      model_clear();
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (d2v) begin
        if (mq.size() < DEPTH) mq.push_back(d2);
        else m_ov = 1;
      end
      m_af = (mq.size() >= DEPTH-2);
      d2 = d1; d2v = d1v; d1v = 0;
      if (v) begin
        part.push_back(proc(x, int'(cfg_shift), cfg_relu));
        if (l || part.size() == LANES) begin
          d1.data = '0;
          for (int i = 0; i < part.size(); i++) d1.data[i*32 +: 32] = part[i];
          d1.cnt  = part.size();
          d1.last = l;
          d1v = 1;
          part.delete();
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] x, input bit l, input bit rdy);
    i_valid = v; i_result = x; i_last = l; ifc.o_ready = rdy;
    @(posedge clk);
    model_edge(v, x, l, rdy);
    @(negedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    i_valid = 0; i_last = 0; ifc.o_ready = 0;
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_async_valid", W'(ifc.o_valid), '0);
    chk("rst_async_data", ifc.o_data, '0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic drain(input string nm, input int expect_n);
    int pops;
    pops = 0;
    for (int k = 0; k < 40; k++) begin
      if (ifc.o_valid) pops++;
      cyc(0, 0, 0, 1);
    end
    chk(nm, W'(pops), W'(expect_n));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", W'(ifc.o_valid), '0);
      chk("rst_data", ifc.o_data, '0);
      chk("rst_count", W'(ifc.o_count), '0);
      chk("rst_last", W'(ifc.o_last), '0);
      chk("rst_af", W'(o_almost_full), '0);
      chk("rst_ov", W'(o_overflow), '0);
    end else begin
      chk("m_valid", W'(ifc.o_valid), W'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("m_data", ifc.o_data, mq[0].data);
        chk("m_count", W'(ifc.o_count), W'(mq[0].cnt));
        chk("m_last", W'(ifc.o_last), W'(mq[0].last));
      end
      chk("m_af", W'(o_almost_full), W'(m_af));
      chk("m_ov", W'(o_overflow), W'(m_ov));
    end
  end

  initial begin
    logic [W-1:0] exp;
    ifc.o_ready = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;

    // Basic packing and 3-cycle latency
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 1, 0);
    chk("lat_c1", W'(ifc.o_valid), '0);
    cyc(0, 0, 0, 0);
    chk("lat_c2", W'(ifc.o_valid), '0);
    cyc(0, 0, 0, 0);
    chk("lat_c3", W'(ifc.o_valid), W'(1));
    exp = {32'd4, 32'd3, 32'd2, 32'd1};
    chk("basic_data", ifc.o_data, exp);
    chk("basic_count", W'(ifc.o_count), W'(4));
    chk("basic_last", W'(ifc.o_last), W'(1));
    cyc(0, 0, 0, 1);
    chk("basic_popped", W'(ifc.o_valid), '0);

    // Partial flush with shift and ReLU
    cfg_shift = 5'd2; cfg_relu = 1'b1;
    cyc(1, 32'd40, 0, 0); cyc(1, 32'hFFFF_FFF4, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    exp = {32'd0, 32'd0, 32'd0, 32'd10};
    chk("relu_data", ifc.o_data, exp);
    chk("relu_count", W'(ifc.o_count), W'(2));
    chk("relu_last", W'(ifc.o_last), W'(1));
    cyc(0, 0, 0, 1);
    cfg_relu = 1'b0;
    cyc(1, 32'd40, 0, 0); cyc(1, 32'hFFFF_FFF4, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    exp = {32'd0, 32'd0, 32'hFFFF_FFFD, 32'd10};
    chk("sra_data", ifc.o_data, exp);
    cyc(0, 0, 0, 1);

    // Extreme shift, then config changed mid-word
    cfg_shift = 5'd31;
    cyc(1, 32'h8000_0000, 0, 0);
    cfg_shift = 5'd1;
    cyc(1, 32'h7FFF_FFFF, 0, 0);
    cfg_shift = 5'd0; cfg_relu = 1'b1;
    cyc(1, 32'hFFFF_FFFB, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    exp = {32'd0, 32'd0, 32'h3FFF_FFFF, 32'hFFFF_FFFF};
    chk("mix_data", ifc.o_data, exp);
    chk("mix_count", W'(ifc.o_count), W'(3));
    cyc(0, 0, 0, 1);
    cfg_relu = 1'b0;

    // Backpressure and overflow: 17 words, 16 stored
    for (int k = 0; k < 4*DEPTH+4; k++) cyc(1, 32'(k), 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("ovf_af", W'(o_almost_full), W'(1));
    chk("ovf_sticky", W'(o_overflow), W'(1));
    exp = {32'd3, 32'd2, 32'd1, 32'd0};
    chk("ovf_head", ifc.o_data, exp);
    drain("ovf_drain_n", DEPTH);
    chk("ovf_after_drain", W'(o_overflow), W'(1));

    // Simultaneous push and pop while full
    rst_pulse();
    for (int k = 0; k < 4*DEPTH; k++) cyc(1, 32'(k + 200), 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("full_af", W'(o_almost_full), W'(1));
    cyc(1, 100, 0, 0); cyc(1, 101, 0, 0); cyc(1, 102, 0, 0); cyc(1, 103, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("pp_no_ovf", W'(o_overflow), '0);
    chk("pp_af", W'(o_almost_full), W'(1));
    drain("pp_drain_n", DEPTH);

    // Reset mid-word with a word still buffered
    rst_pulse();
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("pre_rst_valid", W'(ifc.o_valid), W'(1));
    cyc(1, 11, 0, 0); cyc(1, 12, 0, 0);
    rst_pulse();
    cyc(1, 5, 0, 0); cyc(1, 6, 0, 0); cyc(1, 7, 0, 0); cyc(1, 8, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    exp = {32'd8, 32'd7, 32'd6, 32'd5};
    chk("rst_word_data", ifc.o_data, exp);
    chk("rst_word_count", W'(ifc.o_count), W'(4));
    cyc(0, 0, 0, 1);
    chk("rst_single_word", W'(ifc.o_valid), '0);
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/accum_result_packer.md
Name: accum_result_packer

Overview:
- Sits directly downstream of the MVM accumulator and consumes its `o_valid`/`o_result` stream.
- Applies per-element post-processing: arithmetic right shift, then optional ReLU.
- Packs LANES processed results into one wide word and buffers words in a first-word-fall-through FIFO.
- Drains the FIFO over a valid/ready handshake toward the NoC injection interface.
- The accumulator has no backpressure input, so this block exports an almost-full flag for upstream throttling.

Parameters:
- DATAW, 32, width of one accumulator result, two's complement.
- LANES, 4, results packed per output word.
- DEPTH, 16, output FIFO depth in words (power of 2).
- CNTW, $clog2(LANES+1), width of the lane-count field.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- i_valid  input  1  result strobe from the accumulator (its `o_valid`).
- i_result  input  DATAW  accumulator result (its `o_result`).
- i_last  input  1  marks the final result of a vector; forces a flush of the partial word.
- cfg_shift  input  5  arithmetic right-shift amount.
- cfg_relu  input  1  1 = clamp negative values to 0.
- o_valid  output  1  FIFO head word valid.
- o_ready  input  1  downstream accepts the head word.
- o_data  output  LANES*DATAW  packed word; lane 0 occupies bits [DATAW-1:0].
- o_count  output  CNTW  number of populated lanes in the head word (1..LANES).
- o_last  output  1  head word closes a vector.
- o_almost_full  output  1  FIFO occupancy >= DEPTH-2.
- o_overflow  output  1  sticky: a completed word was dropped.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - o_valid=0, o_data=0, o_count=0, o_last=0, o_almost_full=0, o_overflow=0.
  - FIFO is empty, lane counter is 0, pack register is 0.
- Stage 1 (process), registered, 1 cycle:
  - When i_valid=1, compute y = i_result >>> cfg_shift (sign-preserving).
  - If cfg_relu=1 and y<0, then y=0.
  - Register y, a valid bit and i_last.
  - cfg_shift and cfg_relu are sampled per element in the cycle i_valid is high; changing them mid-word is legal.
  - When i_valid=0 there is no state change; i_last is ignored without i_valid.
- Stage 2 (pack), registered:
  - A lane counter selects the lane; a valid stage-1 element is written into pack[lane].
  - If lane==LANES-1 or the element's last bit is 1, the word completes:
    - Register a push request carrying {pack, count=lane+1, last}.
    - Reset the lane counter to 0 and clear the pack register.
    - Lanes at or above count read as 0.
  - Otherwise the lane counter increments.
  - A new element may arrive every cycle, including the cycle immediately after a completion.
- Stage 3 (FIFO write):
  - A push request writes at the next edge.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped, o_overflow is set, and it stays 1 until rst.
  - The lane counter is unaffected by a drop.
- Latency: i_valid in cycle 0 completing a word gives o_valid=1 in cycle 3 (empty FIFO, no stall).
- Output handshake:
  - o_valid = !empty; o_data, o_count and o_last show the head word.
  - A pop occurs when o_valid && o_ready.
  - o_ready while empty has no effect.
  - Head contents stay stable while o_valid=1 and o_ready=0.
- Occupancy:
  - Tracked with a DEPTH+1-range counter; read/write pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves occupancy unchanged.
  - o_almost_full is registered from occupancy after the update.
- Arithmetic:
  - The shift saturates nothing; cfg_shift >= DATAW yields 0 or -1.
  - No rounding; truncation toward minus infinity.
- Reset mid-operation: the partial word, in-flight stage registers and FIFO contents are all discarded.

Test Plan:
- Basic packing: cfg_shift=0, cfg_relu=0; stream 1,2,3,4 on consecutive cycles with i_last on the 4th. Required: one word with lanes {1,2,3,4}, o_count=4, o_last=1, o_valid rising 3 cycles after the 4th input.
- Partial flush, shift, ReLU: cfg_shift=2, cfg_relu=1; inputs 40, -12, with i_last on the second. Required: word lanes {10,0,0,0}, o_count=2, o_last=1; repeat with cfg_relu=0 and -12 must give lane1=0xFFFFFFFD.
- Backpressure and overflow:
  - Hold o_ready=0 and send 4*DEPTH+4 results.
  - o_almost_full=1 once 14 words are stored.
  - DEPTH=16 words are stored and the 17th is dropped with o_overflow=1.
  - Release o_ready: exactly 16 words drain in order, and o_overflow stays 1.
- Simultaneous push/pop at full: fill to 16, then assert o_ready=1 in the same cycle a new word completes. Required: word accepted, occupancy stays 16, o_overflow remains 0.
- Reset mid-word: send 2 of 4 elements, pulse rst, then send 5,6,7,8 with i_last on the 4th. Required: single word {5,6,7,8}, o_count=4; no stale lanes; all outputs 0 during rst.
